led7_scan_ctrl: RTL

Scan controller for the 8-digit 7-segment display Pmod. It owns the serial shift/latch interface (`sclk`, `serial_data`, `rclk`) of the on-board shift-register chain and refreshes the digits by time multiplexing. Each digit slot sends one 16-bit line word. Upstream logic writes segment patterns into a shadow buffer and commits them; the active frame swaps only at a frame boundary, so no torn frame is ever displayed.

---
 rtl/led7_scan_ctrl_if.sv | 21 ++
 rtl/led7_scan_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/led7_scan_ctrl_if.sv
// led7_scan_ctrl_if: shadow-write/commit bus plus the serial shift/latch lines of the 7-segment scan controller.
interface led7_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       sclk;
  logic       serial_data;
  logic       rclk;
  logic [2:0] digit_idx;
  logic       frame_done;
  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  commit_pending, sclk, serial_data, rclk, digit_idx, frame_done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output commit_pending, sclk, serial_data, rclk, digit_idx, frame_done
  );
endinterface

// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: time-multiplexed 8-digit 7-segment scanner with a double-buffered, frame-aligned commit.
module led7_scan_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int DIGIT_HOLD = 1024
) (
  input logic             clk,
  input logic             rst_n,
  led7_scan_ctrl_if.slave bus
);
  localparam int DH = DIGIT_HOLD < 2 ? 2 : DIGIT_HOLD;
  localparam int HW = $clog2(DH);
  localparam logic [HW-1:0] HMAX = HW'(DH - 1);
  // IDLE decides one cycle early so LOAD lands exactly DIGIT_HOLD cycles after the previous LOAD
  localparam logic [HW-1:0] HTRIG = HW'(DH - 2);
  localparam int PW = CLK_DIV < 2 ? 1 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  state_t          state, state_nx;
  logic [HW-1:0]   hold_cnt;
  logic [PW-1:0]   ph;
  logic [3:0]      bit_cnt;
  logic [15:0]     shreg, word;
  logic [7:0]      shadow [8];
  logic [7:0]      active [8];
  logic            sclk, serial_data, pending, ph_end, frame_done, swap;
  logic [2:0]      digit_idx;
  always_comb begin
    ph_end     = ph == PMAX;
    word       = {active[digit_idx], 8'b1 << digit_idx};
    frame_done = state == LATCH && ph_end && digit_idx == 3'd7;
    swap       = frame_done && (pending || bus.commit);
    state_nx   = state;
    unique case (state)
      IDLE:    state_nx = hold_cnt >= HTRIG ? LOAD : IDLE;
      LOAD:    state_nx = SHIFT;
      SHIFT:   state_nx = ph_end && sclk && bit_cnt == 4'd15 ? LATCH : SHIFT;
      LATCH:   state_nx = ph_end ? IDLE : LATCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= HMAX;
      ph          <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      sclk        <= 1'b0;
      serial_data <= 1'b0;
      digit_idx   <= '0;
      pending     <= 1'b0;
      shadow      <= '{default: '0};
      active      <= '{default: '0};
    end else begin
      state    <= state_nx;
      hold_cnt <= state == LOAD ? '0 : (hold_cnt == HMAX ? HMAX : hold_cnt + 1'b1);
      ph       <= state == LOAD || ph_end ? '0 : ph + 1'b1;
      if (state == LOAD) begin
        shreg       <= word;
        serial_data <= word[15];
        bit_cnt     <= '0;
      end
      if (state == SHIFT && ph_end) begin
        sclk <= ~sclk;
        if (sclk && bit_cnt != 4'd15) begin
          shreg       <= shreg << 1;
          serial_data <= shreg[14];
          bit_cnt     <= bit_cnt + 1'b1;
        end
      end
      if (state == LATCH && ph_end) digit_idx <= digit_idx + 1'b1;
      pending <= swap ? 1'b0 : pending | bus.commit;
      // swap copies the pre-write shadow; a same-cycle write lands in the shadow only
      if (swap) active <= shadow;
      if (bus.wr_en) shadow[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.sclk           = sclk;
  assign bus.serial_data    = serial_data;
  assign bus.rclk           = state == LATCH;
  assign bus.digit_idx      = digit_idx;
  assign bus.frame_done     = frame_done;
  assign bus.commit_pending = pending;
endmodule
